// File: rtl/counter_3bit_driver.sv
// Command-side driver for the 3-bit up/down counter: turns a one-cycle "count N steps" command
// into an N-cycle enable burst, tallies terminal-count events and checks the counter against a shadow value.
module counter_3bit_driver #(
    parameter int MAX_STEPS_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   dir_i,
    input  logic [MAX_STEPS_W-1:0] steps_i,
    input  logic                   abort_i,
    input  logic [2:0]             cnt_par_i,
    input  logic                   cnt_carry_i,
    output logic                   up_cnt_en_o,
    output logic                   down_cnt_en_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic [MAX_STEPS_W-1:0] wrap_cnt_o,
    output logic                   mismatch_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [MAX_STEPS_W-1:0] WRAP_MAX = {MAX_STEPS_W{1'b1}};
    localparam logic [MAX_STEPS_W-1:0] ONE_STEP = MAX_STEPS_W'(1);

    state_e                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic [MAX_STEPS_W-1:0] remaining_q, remaining_d;
    logic [2:0]             exp_q, exp_d;
    logic [MAX_STEPS_W-1:0] wrap_q, wrap_d;
    logic                   mismatch_q, mismatch_d;
    logic                   aborted_q, aborted_d;
    logic                   up_q, up_d;
    logic                   down_q, down_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            exp_q       <= 3'd0;
            wrap_q      <= '0;
            mismatch_q  <= 1'b0;
            aborted_q   <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            exp_q       <= exp_d;
            wrap_q      <= wrap_d;
            mismatch_q  <= mismatch_d;
            aborted_q   <= aborted_d;
            up_q        <= up_d;
            down_q      <= down_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        exp_d       = exp_q;
        wrap_d      = wrap_q;
        mismatch_d  = mismatch_q;
        aborted_d   = aborted_q;
        up_d        = up_q;
        down_d      = down_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dir_d       = dir_i;
                    remaining_d = steps_i;
                    exp_d       = cnt_par_i;
                    wrap_d      = '0;
                    mismatch_d  = 1'b0;
                    aborted_d   = 1'b0;
                    if (steps_i != '0) begin
                        state_d = RUN;
                        up_d    = dir_i;
                        down_d  = ~dir_i;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            RUN: begin
                // The counter moves on every RUN edge, including an abort edge, so the shadow and carry tally follow it.
                exp_d = dir_q ? exp_q + 3'd1 : exp_q - 3'd1;
                if (cnt_carry_i && (wrap_q != WRAP_MAX)) begin
                    wrap_d = wrap_q + ONE_STEP;
                end
                if (remaining_q == ONE_STEP) begin
                    remaining_d = '0;
                    up_d        = 1'b0;
                    down_d      = 1'b0;
                    state_d     = DONE;
                end else if (abort_i) begin
                    aborted_d = 1'b1;
                    up_d      = 1'b0;
                    down_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    remaining_d = remaining_q - ONE_STEP;
                end
            end

            DONE: begin
                if (cnt_par_i != exp_q) begin
                    mismatch_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                up_d    = 1'b0;
                down_d  = 1'b0;
            end
        endcase
    end

    assign up_cnt_en_o   = up_q;
    assign down_cnt_en_o = down_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign aborted_o     = aborted_q;
    assign wrap_cnt_o    = wrap_q;
    assign mismatch_o    = mismatch_q;

endmodule

// File: tb/tb_counter_3bit_driver.sv
// Directed bench for counter_3bit_driver, driving a behavioural 3-bit up/down counter
// whose parallel output can be skewed to provoke a shadow-value mismatch.
module tb_counter_3bit_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dir;
    logic [W-1:0] steps;
    logic         abort;
    logic [2:0]   cntPar;
    logic         cntCarry;
    logic         upEn;
    logic         downEn;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] wrapCnt;
    logic         mismatch;

    logic [2:0]   cntVal = 3'd0;
    logic         loadEn;
    logic [2:0]   loadVal;
    logic [2:0]   parOffset;

    int compared = 0;
    int mismatched = 0;

    int           upCnt;
    int           dnCnt;
    int           doneCnt;
    int           doneCyc;
    int           bothHigh;
    logic         abortedAtDone;
    logic [W-1:0] wrapAtDone;

    always #5 clk = ~clk;

    counter_3bit_driver #(.MAX_STEPS_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .dir_i         (dir),
        .steps_i       (steps),
        .abort_i       (abort),
        .cnt_par_i     (cntPar),
        .cnt_carry_i   (cntCarry),
        .up_cnt_en_o   (upEn),
        .down_cnt_en_o (downEn),
        .busy_o        (busy),
        .done_o        (done),
        .aborted_o     (aborted),
        .wrap_cnt_o    (wrapCnt),
        .mismatch_o    (mismatch)
    );

    // Stand-in for the real counter; it has no reset of its own and is preloaded between tests.
    always @(posedge clk) begin
        if (loadEn)      cntVal <= loadVal;
        else if (upEn)   cntVal <= cntVal + 3'd1;
        else if (downEn) cntVal <= cntVal - 3'd1;
    end

    assign cntCarry = (upEn && cntVal == 3'd7) || (downEn && cntVal == 3'd0);
    assign cntPar   = cntVal + parOffset;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic loadCounter(input logic [2:0] v);
        @(negedge clk);
        loadEn  = 1'b1;
        loadVal = v;
        @(negedge clk);
        loadEn  = 1'b0;
    endtask

    // abortAt: edge after T0 at which abort is sampled (0 = none); forceAt: cycle with skewed cntPar (-1 = none).
    task automatic applyStimulus(input logic dirV, input logic [W-1:0] stepsV, input int abortAt,
                                 input int forceAt, input bit extraStart);
        upCnt = 0; dnCnt = 0; doneCnt = 0; doneCyc = -1; bothHigh = 0;
        abortedAtDone = 1'b0; wrapAtDone = '0;
        @(negedge clk);
        start = 1'b1;
        dir   = dirV;
        steps = stepsV;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < int'(stepsV) + 4; cyc++) begin
            @(negedge clk);
            abort     = (abortAt != 0) && (cyc == abortAt - 1);
            parOffset = (cyc == forceAt) ? 3'd1 : 3'd0;
            start     = extraStart && (cyc == 0);
            if (upEn)           upCnt++;
            if (downEn)         dnCnt++;
            if (upEn && downEn) bothHigh++;
            if (done) begin
                doneCnt++;
                doneCyc       = cyc;
                abortedAtDone = aborted;
                wrapAtDone    = wrapCnt;
            end
        end
        @(negedge clk);
        abort = 1'b0; parOffset = 3'd0; start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; steps = '0; abort = 1'b0;
        loadEn = 1'b0; loadVal = 3'd0; parOffset = 3'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset_up",       upEn,     0);
        checkOutput("reset_down",     downEn,   0);
        checkOutput("reset_busy",     busy,     0);
        checkOutput("reset_done",     done,     0);
        checkOutput("reset_aborted",  aborted,  0);
        checkOutput("reset_wrap",     wrapCnt,  0);
        checkOutput("reset_mismatch", mismatch, 0);
        rst = 1'b0;

        // Abort is ignored while idle.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("idle_abort_busy", busy, 0);

        loadCounter(3'd6);
        applyStimulus(1'b1, 4'd3, 0, -1, 1'b0);
        checkOutput("upwrap_en_cycles", upCnt,    3);
        checkOutput("upwrap_down_en",   dnCnt,    0);
        checkOutput("upwrap_counter",   cntVal,   1);
        checkOutput("upwrap_wrap",      wrapAtDone, 1);
        checkOutput("upwrap_done_cnt",  doneCnt,  1);
        checkOutput("upwrap_done_cyc",  doneCyc,  3);
        checkOutput("upwrap_aborted",   abortedAtDone, 0);
        checkOutput("upwrap_mismatch",  mismatch, 0);
        checkOutput("upwrap_both_high", bothHigh, 0);

        loadCounter(3'd1);
        applyStimulus(1'b0, 4'd10, 0, -1, 1'b0);
        checkOutput("downwrap_en_cycles", dnCnt,    10);
        checkOutput("downwrap_up_en",     upCnt,    0);
        checkOutput("downwrap_counter",   cntVal,   7);
        checkOutput("downwrap_wrap",      wrapAtDone, 2);
        checkOutput("downwrap_done_cyc",  doneCyc,  10);
        checkOutput("downwrap_mismatch",  mismatch, 0);

        loadCounter(3'd5);
        applyStimulus(1'b1, 4'd0, 0, -1, 1'b0);
        checkOutput("zero_up_en",    upCnt,   0);
        checkOutput("zero_down_en",  dnCnt,   0);
        checkOutput("zero_done_cnt", doneCnt, 1);
        checkOutput("zero_done_cyc", doneCyc, 0);
        checkOutput("zero_wrap",     wrapAtDone, 0);
        checkOutput("zero_counter",  cntVal,  5);

        loadCounter(3'd0);
        applyStimulus(1'b1, 4'd8, 3, -1, 1'b0);
        checkOutput("abort_en_cycles", upCnt,    3);
        checkOutput("abort_counter",   cntVal,   3);
        checkOutput("abort_aborted",   abortedAtDone, 1);
        checkOutput("abort_done_cyc",  doneCyc,  3);
        checkOutput("abort_done_cnt",  doneCnt,  1);
        checkOutput("abort_mismatch",  mismatch, 0);

        loadCounter(3'd0);
        applyStimulus(1'b1, 4'd8, 8, -1, 1'b0);
        checkOutput("lastabort_en_cycles", upCnt,    8);
        checkOutput("lastabort_counter",   cntVal,   0);
        checkOutput("lastabort_aborted",   abortedAtDone, 0);
        checkOutput("lastabort_done_cyc",  doneCyc,  8);
        checkOutput("lastabort_wrap",      wrapAtDone, 1);
        checkOutput("lastabort_mismatch",  mismatch, 0);

        loadCounter(3'd2);
        applyStimulus(1'b1, 4'd2, 0, 2, 1'b1);
        checkOutput("skew_en_cycles", upCnt,    2);
        checkOutput("skew_done_cnt",  doneCnt,  1);
        checkOutput("skew_counter",   cntVal,   4);
        checkOutput("skew_mismatch",  mismatch, 1);
        repeat (3) @(negedge clk);
        checkOutput("skew_mismatch_sticky", mismatch, 1);

        // Reset two edges into a five-step burst.
        loadCounter(3'd3);
        @(negedge clk);
        start = 1'b1; dir = 1'b1; steps = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("midrst_mismatch_cleared", mismatch, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_up",   upEn,    0);
        checkOutput("midrst_busy", busy,    0);
        checkOutput("midrst_done", done,    0);
        checkOutput("midrst_wrap", wrapCnt, 0);
        @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("midrst_no_done", doneCnt, 0);

        loadCounter(3'd4);
        applyStimulus(1'b0, 4'd3, 0, -1, 1'b0);
        checkOutput("postrst_en_cycles", dnCnt,    3);
        checkOutput("postrst_counter",   cntVal,   1);
        checkOutput("postrst_done_cnt",  doneCnt,  1);
        checkOutput("postrst_done_cyc",  doneCyc,  3);
        checkOutput("postrst_wrap",      wrapAtDone, 0);
        checkOutput("postrst_mismatch",  mismatch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
